// File: rtl/pfd_digital_if.sv
// Bundle between the reference/feedback sources, the digital PFD and the loop filter.
// The master drives the sampled clocks; the slave (the PFD) returns UP/DN and the phase-error report.
interface pfd_digital_if #(
  parameter int unsigned CNT_W = 10
);
  logic             ref_in;
  logic             fb_in;
  logic             up;
  logic             dn;
  logic [CNT_W:0]   phase_err;
  logic             err_valid;
  logic             slip;

  modport master (
    output ref_in, fb_in,
    input  up, dn, phase_err, err_valid, slip
  );

  modport slave (
    input  ref_in, fb_in,
    output up, dn, phase_err, err_valid, slip
  );
endinterface

// File: rtl/pfd_digital.sv
// Digital phase-frequency detector: IDLE/UP/DN FSM with a signed phase-error count in clk cycles.
// Optional PFD_SYNC_EN adds a 2-flop synchronizer on ref_in and fb_in ahead of edge detection.
module pfd_digital #(
  parameter int unsigned CNT_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  pfd_digital_if.slave  bus
);

  localparam int unsigned ERR_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [ERR_W-1:0]   err_nxt, err_pos, err_neg;
  logic               err_valid_nxt, slip_nxt;
  logic               ref_s, fb_s;
  logic               ref_q, ref_q2, fb_q, fb_q2;
  logic               ref_rise, fb_rise;

`ifdef PFD_SYNC_EN
  logic [1:0] ref_sync, fb_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[0], bus.ref_in};
      fb_sync  <= {fb_sync[0], bus.fb_in};
    end
  end

  assign ref_s = ref_sync[1];
  assign fb_s  = fb_sync[1];
`else
  assign ref_s = bus.ref_in;
  assign fb_s  = bus.fb_in;
`endif

  // Rising-edge detection on the (synchronous) input samples
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q  <= 1'b0;
      ref_q2 <= 1'b0;
      fb_q   <= 1'b0;
      fb_q2  <= 1'b0;
    end else begin
      ref_q  <= ref_s;
      ref_q2 <= ref_q;
      fb_q   <= fb_s;
      fb_q2  <= fb_q;
    end
  end

  assign ref_rise = ref_q & ~ref_q2;
  assign fb_rise  = fb_q & ~fb_q2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ref_rise && !fb_rise)      state_nxt = UP;
        else if (fb_rise && !ref_rise) state_nxt = DN;
      end
      UP:      if (fb_rise && !ref_rise) state_nxt = IDLE;
      DN:      if (ref_rise && !fb_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign err_pos = {1'b0, cnt};
  assign err_neg = (~err_pos) + ERR_W'(1);

  // Counter, error report and slip strobe; a closing edge that coincides with a new lead reloads cnt
  always_comb begin
    cnt_nxt       = cnt;
    err_nxt       = bus.phase_err;
    err_valid_nxt = 1'b0;
    slip_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (ref_rise && fb_rise) begin
          err_valid_nxt = 1'b1;
          err_nxt       = '0;
        end else if (ref_rise || fb_rise) begin
          cnt_nxt = CNT_W'(1);
        end
      end
      UP: begin
        if (fb_rise) begin
          err_valid_nxt = 1'b1;
          err_nxt       = err_pos;
          cnt_nxt       = ref_rise ? CNT_W'(1) : '0;
        end else begin
          slip_nxt = ref_rise;
          cnt_nxt  = cnt_inc;
        end
      end
      DN: begin
        if (ref_rise) begin
          err_valid_nxt = 1'b1;
          err_nxt       = err_neg;
          cnt_nxt       = fb_rise ? CNT_W'(1) : '0;
        end else begin
          slip_nxt = fb_rise;
          cnt_nxt  = cnt_inc;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      bus.phase_err <= '0;
      bus.err_valid <= 1'b0;
      bus.slip      <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      bus.phase_err <= err_nxt;
      bus.err_valid <= err_valid_nxt;
      bus.slip      <= slip_nxt;
    end
  end

  assign bus.up = (state == UP);
  assign bus.dn = (state == DN);

endmodule
